// File: rtl/sprite_rect_blitter_if.sv
// Frame-buffer write port: one pixel write per valid/ready transfer.
// Latency: none (wires only).
// Backpressure: master holds wr_en/wr_addr/wr_data stable while wr_ready is low.
interface sprite_rect_blitter_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 24
);
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/sprite_rect_blitter.sv
// Erases every sprite's previous rectangle, then paints the enabled ones in slot order (higher slot on top).
// Latency: start to done = 2 + 2*NUM_SPRITES + erase cells + draw cells, plus one cycle per stalled write.
// Backpressure: a pending write holds address, data and cell counters until wr_ready; clipped cells never stall.
module sprite_rect_blitter #(
    parameter int NUM_SPRITES = 4,
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int COORD_W     = 8,
    parameter int SIZE_W      = 5,
    parameter int COLOR_W     = 24,
    parameter int ADDR_W      = 15,
    parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(24'hFFFFFF)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES*SIZE_W-1:0]  sprite_w,
    input  logic [NUM_SPRITES*SIZE_W-1:0]  sprite_h,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
    sprite_rect_blitter_if.master          fb,
    output logic                           busy,
    output logic                           done
);
    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPRITES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_ERASE_SETUP, S_ERASE_PIX, S_DRAW_SETUP, S_DRAW_PIX, S_DONE
    } state_t;

    state_t                         state;
    logic [SLOT_W-1:0]              slot;
    logic [SIZE_W-1:0]              dx, dy;

    // Shadow copy of the sprite table taken at the start of a pass
    logic [NUM_SPRITES-1:0]         cur_en;
    logic [NUM_SPRITES*COORD_W-1:0] cur_x, cur_y;
    logic [NUM_SPRITES*SIZE_W-1:0]  cur_w, cur_h;
    logic [NUM_SPRITES*COLOR_W-1:0] cur_color;

    // Rectangles painted by the last completed pass; these are what ERASE clears
    logic [NUM_SPRITES-1:0]         prv_valid;
    logic [NUM_SPRITES*COORD_W-1:0] prv_x, prv_y;
    logic [NUM_SPRITES*SIZE_W-1:0]  prv_w, prv_h;

    logic               erase, pix;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [SIZE_W-1:0]  sel_w, sel_h;
    logic               sel_on;
    logic [COLOR_W-1:0] sel_color;
    logic               last_cell;
    logic [SIZE_W-1:0]  nx, ny, tdx, tdy;
    logic [COORD_W:0]   cx, cy;
    logic [31:0]        a32;
    logic               t_in;
    logic [ADDR_W-1:0]  t_addr;
    state_t             adv_state;
    logic [SLOT_W-1:0]  adv_slot;

    // Current slot's rectangle, the next cell to present, its clip status and the post-slot successor
    always_comb begin
        erase     = (state == S_ERASE_SETUP) || (state == S_ERASE_PIX);
        pix       = (state == S_ERASE_PIX) || (state == S_DRAW_PIX);
        sel_x     = erase ? prv_x[slot*COORD_W +: COORD_W] : cur_x[slot*COORD_W +: COORD_W];
        sel_y     = erase ? prv_y[slot*COORD_W +: COORD_W] : cur_y[slot*COORD_W +: COORD_W];
        sel_w     = erase ? prv_w[slot*SIZE_W +: SIZE_W]   : cur_w[slot*SIZE_W +: SIZE_W];
        sel_h     = erase ? prv_h[slot*SIZE_W +: SIZE_W]   : cur_h[slot*SIZE_W +: SIZE_W];
        sel_on    = (erase ? prv_valid[slot] : cur_en[slot]) && (sel_w != '0) && (sel_h != '0);
        sel_color = erase ? BG_COLOR : cur_color[slot*COLOR_W +: COLOR_W];

        last_cell = (dx == sel_w - SIZE_W'(1)) && (dy == sel_h - SIZE_W'(1));
        if (dx == sel_w - SIZE_W'(1)) begin
            nx = '0;
            ny = dy + SIZE_W'(1);
        end else begin
            nx = dx + SIZE_W'(1);
            ny = dy;
        end
        tdx = pix ? nx : '0;
        tdy = pix ? ny : '0;

        // One extra bit so cells past the right/bottom edge clip instead of wrapping
        cx     = {1'b0, sel_x} + (COORD_W+1)'(tdx);
        cy     = {1'b0, sel_y} + (COORD_W+1)'(tdy);
        t_in   = (32'(cx) < 32'(FB_WIDTH)) && (32'(cy) < 32'(FB_HEIGHT));
        a32    = 32'(cy) * 32'(FB_WIDTH) + 32'(cx);
        t_addr = a32[ADDR_W-1:0];

        if (slot == LAST_SLOT) begin
            adv_slot  = '0;
            adv_state = erase ? S_DRAW_SETUP : S_DONE;
        end else begin
            adv_slot  = slot + SLOT_W'(1);
            adv_state = erase ? S_ERASE_SETUP : S_DRAW_SETUP;
        end
    end

    // Pass sequencer with registered write port, busy and done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            slot       <= '0;
            dx         <= '0;
            dy         <= '0;
            fb.wr_en   <= 1'b0;
            fb.wr_addr <= '0;
            fb.wr_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_en     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            cur_w      <= '0;
            cur_h      <= '0;
            cur_color  <= '0;
            prv_valid  <= '0;
            prv_x      <= '0;
            prv_y      <= '0;
            prv_w      <= '0;
            prv_h      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LATCH;
                        busy  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    cur_en    <= sprite_en;
                    cur_x     <= sprite_x;
                    cur_y     <= sprite_y;
                    cur_w     <= sprite_w;
                    cur_h     <= sprite_h;
                    cur_color <= sprite_color;
                    slot      <= '0;
                    state     <= S_ERASE_SETUP;
                end
                S_ERASE_SETUP, S_DRAW_SETUP: begin
                    if (sel_on) begin
                        dx         <= '0;
                        dy         <= '0;
                        fb.wr_en   <= t_in;
                        if (t_in) fb.wr_addr <= t_addr;
                        fb.wr_data <= sel_color;
                        state      <= erase ? S_ERASE_PIX : S_DRAW_PIX;
                    end else begin
                        state <= adv_state;
                        slot  <= adv_slot;
                        done  <= (adv_state == S_DONE);
                    end
                end
                S_ERASE_PIX, S_DRAW_PIX: begin
                    if (!fb.wr_en || fb.wr_ready) begin
                        if (last_cell) begin
                            fb.wr_en <= 1'b0;
                            state    <= adv_state;
                            slot     <= adv_slot;
                            done     <= (adv_state == S_DONE);
                        end else begin
                            dx       <= nx;
                            dy       <= ny;
                            fb.wr_en <= t_in;
                            if (t_in) fb.wr_addr <= t_addr;
                        end
                    end
                end
                S_DONE: begin
                    prv_valid <= cur_en;
                    prv_x     <= cur_x;
                    prv_y     <= cur_y;
                    prv_w     <= cur_w;
                    prv_h     <= cur_h;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_rect_blitter.sv
// Self-checking bench: fixed pass table, reset/backpressure sequences, randomized passes vs. a painter model.
// Latency: checks start-to-done cycle counts against the cell-count formula.
// Backpressure: drives wr_ready always-on, toggling and random; checks stalled writes are held.
module tb_sprite_rect_blitter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  s_en;
    logic [N*8-1:0]  s_x, s_y;
    logic [N*5-1:0]  s_w, s_h;
    logic [N*24-1:0] s_c;
    logic          busy, done;

    sprite_rect_blitter_if #(.ADDR_W(15), .COLOR_W(24)) fb();

    sprite_rect_blitter dut (
        .clk(clk), .rst(rst), .start(start),
        .sprite_en(s_en), .sprite_x(s_x), .sprite_y(s_y),
        .sprite_w(s_w), .sprite_h(s_h), .sprite_color(s_c),
        .fb(fb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference painter state: what the previous completed pass drew
    bit   m_pv[N];
    int   m_px[N], m_py[N], m_pw[N], m_ph[N];
    int   exp_addr[$];
    logic [23:0] exp_data[$];
    int   exp_lat;
    int   got_addr[$];
    logic [23:0] got_data[$];

    task automatic model_pass();
        int cells;
        cells = 0;
        exp_addr.delete();
        exp_data.delete();
        for (int ph = 0; ph < 2; ph++) begin
            for (int s = 0; s < N; s++) begin
                int x, y, w, h;
                bit on;
                logic [23:0] c;
                if (ph == 0) begin
                    on = m_pv[s]; x = m_px[s]; y = m_py[s]; w = m_pw[s]; h = m_ph[s];
                    c = 24'hFFFFFF;
                end else begin
                    on = s_en[s]; x = int'(s_x[s*8 +: 8]); y = int'(s_y[s*8 +: 8]);
                    w = int'(s_w[s*5 +: 5]); h = int'(s_h[s*5 +: 5]); c = s_c[s*24 +: 24];
                end
                if (on && w > 0 && h > 0) begin
                    for (int yy = 0; yy < h; yy++) begin
                        for (int xx = 0; xx < w; xx++) begin
                            cells++;
                            if (x + xx < 160 && y + yy < 120) begin
                                exp_addr.push_back((y + yy) * 160 + x + xx);
                                exp_data.push_back(c);
                            end
                        end
                    end
                end
            end
        end
        for (int s = 0; s < N; s++) begin
            m_pv[s] = s_en[s];
            m_px[s] = int'(s_x[s*8 +: 8]); m_py[s] = int'(s_y[s*8 +: 8]);
            m_pw[s] = int'(s_w[s*5 +: 5]); m_ph[s] = int'(s_h[s*5 +: 5]);
        end
        exp_lat = 2 + 2 * N + cells;
    endtask

    task automatic set_slot(input int i, input bit en, input int x, input int y,
                            input int w, input int h, input logic [23:0] c);
        s_en[i]        = en;
        s_x[i*8 +: 8]  = 8'(x);
        s_y[i*8 +: 8]  = 8'(y);
        s_w[i*5 +: 5]  = 5'(w);
        s_h[i*5 +: 5]  = 5'(h);
        s_c[i*24 +: 24] = c;
    endtask

    task automatic randomize_slots();
        for (int s = 0; s < N; s++) begin
            int x, y;
            x = ($urandom % 3 == 0) ? int'($urandom_range(150, 200)) : int'($urandom_range(0, 159));
            y = ($urandom % 3 == 0) ? int'($urandom_range(110, 140)) : int'($urandom_range(0, 119));
            set_slot(s, 1'($urandom), x, y, int'($urandom_range(0, 8)), int'($urandom_range(0, 6)),
                     24'($urandom));
        end
    endtask

    // ready modes: 0 always ready, 1 toggling 1010..., 2 random
    task automatic run_pass(input int rmode, input bit extra, input bit scramble,
                            output int lat, output int stalls, output bit tmo,
                            output int holdbad, output bit tail_bad);
        bit prev_stall;
        int pa;
        logic [23:0] pd;
        got_addr.delete();
        got_data.delete();
        lat = -1; stalls = 0; tmo = 1'b1; holdbad = 0; prev_stall = 1'b0; pa = 0; pd = '0;
        @(negedge clk);
        start = 1'b1;
        fb.wr_ready = 1'b1;
        for (int c = 1; c < 4000; c++) begin
            @(negedge clk);
            start = extra && (c == 5);
            if (scramble && c == 3) randomize_slots();
            case (rmode)
                0:       fb.wr_ready = 1'b1;
                1:       fb.wr_ready = (c % 2 == 0);
                default: fb.wr_ready = 1'($urandom);
            endcase
            if (prev_stall && (fb.wr_en !== 1'b1 || int'(fb.wr_addr) != pa || fb.wr_data !== pd))
                holdbad++;
            if (fb.wr_en && fb.wr_ready) begin
                got_addr.push_back(int'(fb.wr_addr));
                got_data.push_back(fb.wr_data);
            end
            prev_stall = fb.wr_en && !fb.wr_ready;
            if (prev_stall) stalls++;
            pa = int'(fb.wr_addr);
            pd = fb.wr_data;
            if (done === 1'b1) begin
                lat = c;
                tmo = 1'b0;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        tail_bad = (done !== 1'b0) || (busy !== 1'b0);
    endtask

    task automatic compare_model(input string tag, input int lat, input int stalls,
                                 input bit tmo, input int holdbad, input bit tail_bad);
        int bad;
        bad = 0;
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) bad++;
        chk({tag, "_timeout"}, 64'(tmo), 64'd0);
        chk({tag, "_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        chk({tag, "_seq"}, 64'(bad), 64'd0);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat + stalls));
        chk({tag, "_hold"}, 64'(holdbad), 64'd0);
        chk({tag, "_tail"}, 64'(tail_bad), 64'd0);
    endtask

    typedef struct {
        bit [3:0]    en;
        int          x0, y0, w0, h0;
        logic [23:0] c0;
        int          x1, y1, w1, h1;
        logic [23:0] c1;
        int          exp_n, exp_lat, first_addr, last_addr;
        logic [23:0] last_data;
        bit          extra_start;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int lat, stalls, holdbad, fa, la;
        bit tmo, tail_bad, seen;
        logic [23:0] ld;

        tbl[0] = '{4'b0001, 10, 5, 2, 2, 24'h7F2B0A, 0, 0, 0, 0, 24'h0,
                   4, 14, 810, 971, 24'h7F2B0A, 1'b0};
        tbl[1] = '{4'b0001, 11, 5, 2, 2, 24'h7F2B0A, 0, 0, 0, 0, 24'h0,
                   8, 18, 810, 972, 24'h7F2B0A, 1'b0};
        tbl[2] = '{4'b0001, 158, 119, 4, 2, 24'h7F2B0A, 0, 0, 0, 0, 24'h0,
                   6, 22, 811, 19199, 24'h7F2B0A, 1'b0};
        tbl[3] = '{4'b0011, 20, 20, 3, 1, 24'hAAAAAA, 20, 20, 3, 1, 24'hBBBBBB,
                   8, 24, 19198, 3222, 24'hBBBBBB, 1'b1};

        rst = 1'b1; start = 1'b0; fb.wr_ready = 1'b0;
        s_en = '0; s_x = '0; s_y = '0; s_w = '0; s_h = '0; s_c = '0;
        for (int s = 0; s < N; s++) begin
            m_pv[s] = 1'b0; m_px[s] = 0; m_py[s] = 0; m_pw[s] = 0; m_ph[s] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_wr_en", 64'(fb.wr_en), 64'd0);
        chk("reset_wr_addr", 64'(fb.wr_addr), 64'd0);
        chk("reset_wr_data", 64'(fb.wr_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            set_slot(0, tbl[i].en[0], tbl[i].x0, tbl[i].y0, tbl[i].w0, tbl[i].h0, tbl[i].c0);
            set_slot(1, tbl[i].en[1], tbl[i].x1, tbl[i].y1, tbl[i].w1, tbl[i].h1, tbl[i].c1);
            set_slot(2, tbl[i].en[2], 0, 0, 3, 3, 24'h123456);
            set_slot(3, tbl[i].en[3], 5, 5, 2, 2, 24'h654321);
            model_pass();
            run_pass(0, tbl[i].extra_start, 1'b0, lat, stalls, tmo, holdbad, tail_bad);
            compare_model(tag, lat, stalls, tmo, holdbad, tail_bad);
            fa = (got_addr.size() > 0) ? got_addr[0] : -1;
            la = (got_addr.size() > 0) ? got_addr[$] : -1;
            ld = (got_data.size() > 0) ? got_data[$] : 24'hxxxxxx;
            chk({tag, "_n_const"}, 64'(got_addr.size()), 64'(tbl[i].exp_n));
            chk({tag, "_lat_const"}, 64'(lat), 64'(tbl[i].exp_lat));
            chk({tag, "_first_addr"}, 64'(fa), 64'(tbl[i].first_addr));
            chk({tag, "_last_addr"}, 64'(la), 64'(tbl[i].last_addr));
            chk({tag, "_last_data"}, 64'(ld), 64'(tbl[i].last_data));
        end

        // Reset in the middle of a pass, while a write is being presented
        set_slot(0, 1'b1, 0, 0, 31, 31, 24'h00FF00);
        @(negedge clk);
        start = 1'b1; fb.wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (fb.wr_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rstmid_saw_write", 64'(seen), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_wr_en", 64'(fb.wr_en), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < N; s++) m_pv[s] = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_idle_after", 64'(fb.wr_en | busy), 64'd0);

        // Backpressure with toggling ready on the single-sprite case; nothing left to erase
        set_slot(0, 1'b1, 10, 5, 2, 2, 24'h7F2B0A);
        set_slot(1, 1'b0, 40, 40, 2, 2, 24'h111111);
        set_slot(2, 1'b0, 0, 0, 3, 3, 24'h123456);
        set_slot(3, 1'b0, 5, 5, 2, 2, 24'h654321);
        model_pass();
        run_pass(1, 1'b0, 1'b0, lat, stalls, tmo, holdbad, tail_bad);
        compare_model("bp", lat, stalls, tmo, holdbad, tail_bad);
        chk("bp_n", 64'(got_addr.size()), 64'd4);
        chk("bp_first_addr", 64'((got_addr.size() > 0) ? got_addr[0] : -1), 64'd810);
        chk("bp_stalled", 64'(stalls > 0), 64'd1);
        chk("bp_latency", 64'(lat), 64'(14 + stalls));

        // Randomized passes against the painter model; inputs scrambled after latch
        for (int r = 0; r < 8; r++) begin
            randomize_slots();
            model_pass();
            run_pass(2, 1'($urandom), 1'b1, lat, stalls, tmo, holdbad, tail_bad);
            compare_model($sformatf("rnd%0d", r), lat, stalls, tmo, holdbad, tail_bad);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
